inst_fetch: RTL

//  Fetch stage directly upstream of the decode stage (id). Generates sequential PCs and

---
 rtl/inst_fetch_pkg.sv | 24 ++
 rtl/inst_fetch_fifo.sv | 78 +++++++
 rtl/inst_fetch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   INST_ADDR_W / INST_W : PC and instruction word widths
//   ZERO_WORD            : value presented on pc/inst when no instruction is held
//   PC_STEP              : sequential PC increment (one 32-bit word)
//   fetch_entry_t        : {pc, inst} pair buffered between ROM and decode
//   word_align()         : clears the byte-offset bits of an address
package inst_fetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic [INST_W-1:0]      ZERO_WORD = '0;
    localparam logic [INST_ADDR_W-1:0] PC_STEP   = INST_ADDR_W'(4);

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous fetch buffer holding {pc, inst} entries for the decode stage.
//   clk, rst      : clock, synchronous active-high reset
//   flush_i       : empty the buffer; wins over a push in the same cycle
//   push_i/wdata_i: write one entry
//   pop_i         : consume the head entry (ignored when empty)
//   rdata_o       : head entry
//   count_o       : number of stored entries (0..DEPTH)
//   empty_o/full_o: occupancy flags
module inst_fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     wdata_i,
    input  logic             pop_i,
    output fetch_entry_t     rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;
    logic             mem_we;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer/occupancy update; a full buffer still accepts a push when popping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        mem_we   = do_push && !flush_i;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: issues sequential PCs to the instruction ROM (req/gnt/rvalid,
// in-order returns), buffers {pc, inst} pairs and hands them to decode.
//   clk, rst                    : clock, synchronous active-high reset
//   rom_req_o/rom_addr_o        : ROM request and word address
//   rom_gnt_i                   : ROM accepted the request this cycle
//   rom_rvalid_i/rom_rdata_i    : in-order ROM response
//   redirect_i/redirect_pc_i    : restart fetch at a new target, discard in-flight work
//   valid_o/ready_i             : decode handshake
//   pc_o/inst_o                 : head instruction, zero when !valid_o
//   err_o                       : sticky, response seen with nothing outstanding
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned            FIFO_DEPTH = 4,
    parameter logic [INST_ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_req_o,
    output logic [INST_ADDR_W-1:0] rom_addr_o,
    input  logic                   rom_gnt_i,
    input  logic                   rom_rvalid_i,
    input  logic [INST_W-1:0]      rom_rdata_i,
    input  logic                   redirect_i,
    input  logic [INST_ADDR_W-1:0] redirect_pc_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0]      inst_o,
    output logic                   err_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [INST_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [INST_ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]       outst_q, outst_d;
    logic [CNT_W-1:0]       drop_q, drop_d;
    logic                   err_q, err_d;

    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_push;
    logic                   fifo_pop;
    fetch_entry_t           fifo_head;
    fetch_entry_t           push_entry;

    logic [SUM_W-1:0]       credit_used;
    logic                   issue;
    logic                   rsp_ok;
    logic                   rsp_spur;

    // ROM handshake and decode-side outputs.
    always_comb begin
        credit_used = SUM_W'(outst_q) + SUM_W'(fifo_count);
        // Outstanding requests reserve FIFO slots, so a response can always be stored.
        rom_req_o   = !rst && !redirect_i && (credit_used < SUM_W'(FIFO_DEPTH));
        rom_addr_o  = fetch_pc_q;
        issue       = rom_req_o && rom_gnt_i;
        rsp_ok      = rom_rvalid_i && (outst_q != '0);
        rsp_spur    = rom_rvalid_i && (outst_q == '0);

        valid_o     = !rst && !fifo_empty;
        fifo_pop    = valid_o && ready_i;
        fifo_push   = rsp_ok && (drop_q == '0) && !redirect_i;
        push_entry.pc   = resp_pc_q;
        push_entry.inst = rom_rdata_i;

        pc_o   = valid_o ? fifo_head.pc   : ZERO_WORD;
        inst_o = valid_o ? fifo_head.inst : ZERO_WORD;
        err_o  = err_q;
    end

    // PC, credit and drop bookkeeping.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        err_d      = err_q;
        if (redirect_i) begin
            // No issue this cycle; every request still in flight must be discarded.
            fetch_pc_d = word_align(redirect_pc_i);
            resp_pc_d  = word_align(redirect_pc_i);
            outst_d    = outst_q - CNT_W'(rsp_ok);
            drop_d     = outst_q - CNT_W'(rsp_ok);
        end else begin
            if (issue)     fetch_pc_d = fetch_pc_q + PC_STEP;
            if (fifo_push) resp_pc_d  = resp_pc_q + PC_STEP;
            outst_d = outst_q + CNT_W'(issue) - CNT_W'(rsp_ok);
            if (rsp_ok && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
        end
        if (rsp_spur) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    inst_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_i),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // The credit scheme must never present a push to a full buffer that is not draining.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule
